// File: rtl/dmux4way16_router_pkg.sv
// -----------------------------------------------------------------------------
// hack_pkg
// Shared constants and types for the 4-way 16-bit demultiplexing router.
//   WORD_W        : data word width (16)
//   LANES         : number of output lanes (4)
//   SEL_W         : lane select width (2)
//   word_t        : one data word
//   sel_t         : lane select value
//   LANE_A..LANE_D: select encodings for lanes a..d
// -----------------------------------------------------------------------------
package hack_pkg;

    localparam int WORD_W = 16;
    localparam int LANES  = 4;
    localparam int SEL_W  = 2;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [SEL_W-1:0]  sel_t;

    localparam sel_t LANE_A = 2'd0;
    localparam sel_t LANE_B = 2'd1;
    localparam sel_t LANE_C = 2'd2;
    localparam sel_t LANE_D = 2'd3;

endpackage : hack_pkg

// File: rtl/dmux4way16_router_lane.sv
// -----------------------------------------------------------------------------
// dmux_lane
// One-entry output buffer for a single router lane.
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset (clears full flag and data)
//   load       : write load_data into the buffer this cycle
//   load_data  : word to store
//   out_ready  : consumer takes the stored word this cycle
//   valid      : buffer holds a word
//   data       : stored word (held after draining)
//   can_accept : buffer can take a word this cycle (empty, or draining now)
// -----------------------------------------------------------------------------
module dmux_lane
    import hack_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  word_t load_data,
    input  logic  out_ready,
    output logic  valid,
    output word_t data,
    output logic  can_accept
);

    logic  r_full;
    word_t r_data;

    // Load has priority over drain so a same-cycle load/drain keeps the
    // lane full with the new word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (load) begin
            r_full <= 1'b1;
            r_data <= load_data;
        end else if (r_full && out_ready) begin
            r_full <= 1'b0;
        end
    end

    assign valid      = r_full;
    assign data       = r_data;
    assign can_accept = ~r_full | out_ready;

endmodule : dmux_lane

// File: rtl/dmux4way16_router.sv
// -----------------------------------------------------------------------------
// dmux4way16_router
// Routes a 16-bit valid/ready word stream to one of four lanes by in_sel.
// Each lane has its own one-entry register, so a stalled lane only blocks
// words addressed to that lane.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : producer presents a word
//   in_ready  : word accepted this cycle (combinational from in_sel,
//               lane state and out_ready)
//   in_data   : word to route
//   in_sel    : destination lane (00=a, 01=b, 10=c, 11=d)
//   out_valid : bit i set when lane i holds a word
//   out_ready : bit i set when consumer i takes lane i's word
//   out_a..d  : lane data registers
// -----------------------------------------------------------------------------
module dmux4way16_router
    import hack_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  word_t            in_data,
    input  sel_t             in_sel,
    output logic [LANES-1:0] out_valid,
    input  logic [LANES-1:0] out_ready,
    output word_t            out_a,
    output word_t            out_b,
    output word_t            out_c,
    output word_t            out_d
);

    logic [LANES-1:0] w_can_accept;
    logic [LANES-1:0] w_load;
    word_t            w_data [LANES];

    assign in_ready = w_can_accept[in_sel];

    always_comb begin
        w_load = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            w_load[i] = in_valid && in_ready && (in_sel == sel_t'(i));
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        dmux_lane u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .load       (w_load[g]),
            .load_data  (in_data),
            .out_ready  (out_ready[g]),
            .valid      (out_valid[g]),
            .data       (w_data[g]),
            .can_accept (w_can_accept[g])
        );
    end

    assign out_a = w_data[LANE_A];
    assign out_b = w_data[LANE_B];
    assign out_c = w_data[LANE_C];
    assign out_d = w_data[LANE_D];

endmodule : dmux4way16_router

// File: tb/tb_dmux4way16_router.sv
// -----------------------------------------------------------------------------
// tb_dmux4way16_router
// Self-checking bench for dmux4way16_router: directed table, reset
// sequences and randomized traffic against a queue-based lane model.
// -----------------------------------------------------------------------------
module tb_dmux4way16_router;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [1:0]  in_sel;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [15:0] out_a, out_b, out_c, out_d;

    dmux4way16_router dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_c     (out_c),
        .out_d     (out_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: each lane is a queue of at most one word, plus the
    // last word ever written (what the data output keeps showing).
    logic [15:0] mq [4][$];
    logic [15:0] mlast [4];

    typedef struct {
        logic        v;
        logic [1:0]  sel;
        logic [15:0] d;
        logic [3:0]  rdy;
        logic        e_ir;
        logic [3:0]  e_v;
        logic [15:0] e_a, e_b, e_c, e_d;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mq[i].delete();
            mlast[i] = 16'h0000;
        end
    endtask

    function automatic logic model_ready(input logic [1:0] sel, input logic [3:0] rdy);
        return (mq[sel].size() == 0) || rdy[sel];
    endfunction

    task automatic model_clock(input logic v, input logic [1:0] sel,
                               input logic [15:0] d, input logic [3:0] rdy);
        logic acc;
        acc = v && model_ready(sel, rdy);
        for (int i = 0; i < 4; i++)
            if (rdy[i] && mq[i].size() != 0) void'(mq[i].pop_front());
        if (acc) begin
            mq[sel].push_back(d);
            mlast[sel] = d;
        end
    endtask

    task automatic chk_outputs_model(input string tag);
        logic [3:0] ev;
        for (int i = 0; i < 4; i++) ev[i] = (mq[i].size() != 0);
        chk({tag, ".valid"}, {28'd0, out_valid}, {28'd0, ev});
        chk({tag, ".a"}, {16'd0, out_a}, {16'd0, mlast[0]});
        chk({tag, ".b"}, {16'd0, out_b}, {16'd0, mlast[1]});
        chk({tag, ".c"}, {16'd0, out_c}, {16'd0, mlast[2]});
        chk({tag, ".d"}, {16'd0, out_d}, {16'd0, mlast[3]});
    endtask

    // One cycle: drive after the falling edge, check in_ready before the
    // rising edge, then check registered outputs just after it.
    task automatic step(input logic v, input logic [1:0] sel, input logic [15:0] d,
                        input logic [3:0] rdy, input string tag, output logic ir);
        @(negedge clk);
        in_valid  = v;
        in_sel    = sel;
        in_data   = d;
        out_ready = rdy;
        #1;
        ir = in_ready;
        chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, model_ready(sel, rdy)});
        @(posedge clk);
        model_clock(v, sel, d, rdy);
        #1;
        chk_outputs_model(tag);
    endtask

    function automatic vec_t mk(input logic v, input logic [1:0] sel, input logic [15:0] d,
                                input logic [3:0] rdy, input logic eir, input logic [3:0] ev,
                                input logic [15:0] ea, input logic [15:0] eb,
                                input logic [15:0] ec, input logic [15:0] ed);
        vec_t r;
        r.v = v; r.sel = sel; r.d = d; r.rdy = rdy; r.e_ir = eir; r.e_v = ev;
        r.e_a = ea; r.e_b = eb; r.e_c = ec; r.e_d = ed;
        return r;
    endfunction

    initial begin
        logic        ir;
        logic        pv;
        logic [1:0]  ps;
        logic [15:0] pd;
        logic [3:0]  rr;

        // Directed sequence from reset: fill, full block, isolation,
        // same-cycle replace, drain, refill, all-full corners.
        tbl[0]  = mk(1, 2'd0, 16'h5555, 4'b0000, 1, 4'b0001, 16'h5555, 16'h0000, 16'h0000, 16'h0000);
        tbl[1]  = mk(1, 2'd1, 16'hAAAA, 4'b0000, 1, 4'b0011, 16'h5555, 16'hAAAA, 16'h0000, 16'h0000);
        tbl[2]  = mk(1, 2'd2, 16'h00FF, 4'b0000, 1, 4'b0111, 16'h5555, 16'hAAAA, 16'h00FF, 16'h0000);
        tbl[3]  = mk(1, 2'd3, 16'hFF00, 4'b0000, 1, 4'b1111, 16'h5555, 16'hAAAA, 16'h00FF, 16'hFF00);
        tbl[4]  = mk(1, 2'd2, 16'hDEAD, 4'b0000, 0, 4'b1111, 16'h5555, 16'hAAAA, 16'h00FF, 16'hFF00);
        tbl[5]  = mk(0, 2'd1, 16'h0000, 4'b0010, 1, 4'b1101, 16'h5555, 16'hAAAA, 16'h00FF, 16'hFF00);
        tbl[6]  = mk(1, 2'd1, 16'h1234, 4'b0000, 1, 4'b1111, 16'h5555, 16'h1234, 16'h00FF, 16'hFF00);
        tbl[7]  = mk(1, 2'd2, 16'hBEEF, 4'b0100, 1, 4'b1111, 16'h5555, 16'h1234, 16'hBEEF, 16'hFF00);
        tbl[8]  = mk(0, 2'd0, 16'h0000, 4'b1111, 1, 4'b0000, 16'h5555, 16'h1234, 16'hBEEF, 16'hFF00);
        tbl[9]  = mk(1, 2'd0, 16'h0011, 4'b0000, 1, 4'b0001, 16'h0011, 16'h1234, 16'hBEEF, 16'hFF00);
        tbl[10] = mk(1, 2'd1, 16'h0022, 4'b0000, 1, 4'b0011, 16'h0011, 16'h0022, 16'hBEEF, 16'hFF00);
        tbl[11] = mk(1, 2'd2, 16'h0033, 4'b0000, 1, 4'b0111, 16'h0011, 16'h0022, 16'h0033, 16'hFF00);
        tbl[12] = mk(1, 2'd3, 16'h0044, 4'b0000, 1, 4'b1111, 16'h0011, 16'h0022, 16'h0033, 16'h0044);
        tbl[13] = mk(0, 2'd0, 16'h0000, 4'b0000, 0, 4'b1111, 16'h0011, 16'h0022, 16'h0033, 16'h0044);
        tbl[14] = mk(0, 2'd1, 16'h0000, 4'b0000, 0, 4'b1111, 16'h0011, 16'h0022, 16'h0033, 16'h0044);
        tbl[15] = mk(0, 2'd2, 16'h0000, 4'b0000, 0, 4'b1111, 16'h0011, 16'h0022, 16'h0033, 16'h0044);
        tbl[16] = mk(0, 2'd3, 16'h0000, 4'b0000, 0, 4'b1111, 16'h0011, 16'h0022, 16'h0033, 16'h0044);
        tbl[17] = mk(1, 2'd3, 16'h9999, 4'b1111, 1, 4'b1000, 16'h0011, 16'h0022, 16'h0033, 16'h9999);
        tbl[18] = mk(1, 2'd0, 16'h0101, 4'b0000, 1, 4'b1001, 16'h0101, 16'h0022, 16'h0033, 16'h9999);

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = 16'h0000;
        out_ready = 4'b0000;
        model_reset();

        // Reset values, with in_ready checked for every select.
        #2;
        chk("rst.valid", {28'd0, out_valid}, 32'd0);
        chk("rst.outs", {out_a, out_b}, 32'd0);
        chk("rst.outs2", {out_c, out_d}, 32'd0);
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1;
            chk($sformatf("rst.in_ready%0d", s), {31'd0, in_ready}, 32'd1);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 19; k++) begin
            step(tbl[k].v, tbl[k].sel, tbl[k].d, tbl[k].rdy, $sformatf("tbl%0d", k), ir);
            chk($sformatf("tbl%0d.exp_ir", k), {31'd0, ir}, {31'd0, tbl[k].e_ir});
            chk($sformatf("tbl%0d.exp_valid", k), {28'd0, out_valid}, {28'd0, tbl[k].e_v});
            chk($sformatf("tbl%0d.exp_ab", k), {out_a, out_b}, {tbl[k].e_a, tbl[k].e_b});
            chk($sformatf("tbl%0d.exp_cd", k), {out_c, out_d}, {tbl[k].e_c, tbl[k].e_d});
        end

        // Mid-operation reset: fill the rest, then pulse rst_n between edges.
        step(1, 2'd1, 16'h0202, 4'b0000, "mr.fill1", ir);
        step(1, 2'd2, 16'h0303, 4'b0000, "mr.fill2", ir);
        chk("mr.full", {28'd0, out_valid}, 32'hF);
        @(negedge clk);
        in_valid = 1'b1; in_sel = 2'd1; in_data = 16'h7777; out_ready = 4'b0000;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mr.async_valid", {28'd0, out_valid}, 32'd0);
        chk("mr.async_ab", {out_a, out_b}, 32'd0);
        chk("mr.async_cd", {out_c, out_d}, 32'd0);
        chk("mr.in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("mr.no_load_in_reset", {28'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        model_clock(1, 2'd1, 16'h7777, 4'b0000);
        #1;
        chk("mr.first_edge_load", {28'd0, out_valid}, 32'h2);
        chk("mr.first_edge_b", {16'd0, out_b}, 32'h7777);
        chk_outputs_model("mr.model");

        // Randomized traffic; the producer holds its word until accepted.
        pv = 1'b0; ps = 2'd0; pd = 16'h0000;
        for (int c = 0; c < 400; c++) begin
            if (!pv) begin
                pv = ($urandom_range(0, 3) != 0);
                ps = 2'($urandom_range(0, 3));
                pd = 16'($urandom);
            end
            rr = 4'($urandom);
            step(pv, ps, pd, rr, $sformatf("rnd%0d", c), ir);
            if (pv && ir) pv = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_dmux4way16_router

// File: doc/dmux4way16_router.md
# dmux4way16_router

Write-side counterpart of the 4-way 16-bit mux: routes one 16-bit input word stream to one of four output lanes by a 2-bit select, with valid/ready handshakes on both sides. Each lane owns a one-entry output register, so a stalled lane never blocks words bound for other lanes once the head word is accepted. It sits between a single producer and four independent consumers, for example register-bank write ports or per-unit command queues.

## Interface
- No parameters. Data width is fixed at 16 and lane count at 4, both taken from the shared package.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: producer presents a word.
- `in_ready` output 1: router accepts the word this cycle. Combinational from `in_sel`, lane state and `out_ready`.
- `in_data` input 16: word to route.
- `in_sel` input 2: destination lane. 00 = a, 01 = b, 10 = c, 11 = d.
- `out_valid` output 4: bit i set means lane i holds a word.
- `out_ready` input 4: bit i set means consumer i takes lane i's word this cycle.
- `out_a`, `out_b`, `out_c`, `out_d` output 16 each: lane data registers.

## Operation
- Per-lane state: `full[i]` (1 bit) and `data[i]` (16 bits). `out_valid[i] = full[i]` and `out_x = data[i]`.
- Reset: all `full` = 0, all lane data = 16'h0000. The outputs therefore reset to `out_valid` = 4'b0000, `out_a..d` = 0, and `in_ready` = 1 for any `in_sel`.
- Lane draining: `drain[i] = full[i] & out_ready[i]`.
- `in_ready = ~full[in_sel] | out_ready[in_sel]`. A word is accepted into a full lane when that lane drains in the same cycle.
- Accept when `in_valid & in_ready`. Lane `in_sel` loads `in_data` and sets `full`.
- Per-lane next state, evaluated in priority order:
  - Load: `full` = 1 and data = `in_data`.
  - Drain without load: `full` = 0 and data is held.
  - Otherwise: hold.
- Load and drain on the same lane in the same cycle: the new word replaces the old one and `full` stays 1, so throughput is one word per cycle per lane.
- Lanes not selected are unaffected by the input side. They drain independently in the same cycle.
- `in_sel` and `in_data` are ignored when `in_valid` = 0.
- `out_x` data holds its last value after draining. Consumers must qualify it with `out_valid`.
- While `out_valid[i]` = 1 and `out_ready[i]` = 0, lane i data and valid are stable.
- Producer rule: once `in_valid` is asserted, the producer holds `in_valid`, `in_data` and `in_sel` until acceptance.

## Timing
- Latency: a word accepted at edge N appears on `out_valid`/`out_x` right after edge N. That is one cycle of input-to-output latency.
- There is no combinational path from `in_data` to any `out_x`. The only combinational path is `out_ready`/`in_sel` to `in_ready`.
- Reset mid-operation: an asynchronous clear drops all stored words immediately. No handshake completes in the cycle `rst_n` rises. Operation resumes on the first edge with `rst_n` = 1.
- Wrap-around and boundary cases:
  - All four lanes full with no ready: `in_ready` = 0 for every select.
  - All four full with all ready: any select is accepted, and the other three lanes empty.

## Structure
- Shared package `hack_pkg` holds:
  - `WORD_W = 16`
  - `LANES = 4`
  - `SEL_W = 2`
  - `typedef logic [WORD_W-1:0] word_t`
  - lane index constants `LANE_A..LANE_D`
- Sub-module `dmux_lane`: one-entry buffer holding the `full` flag and the data register. Its inputs are `load`, `load_data` and `out_ready`. Its outputs are `valid`, `data` and `can_accept` (= `~full | out_ready`). The router instantiates four of them.
- The top level contains only select decoding and the `in_ready` mux.

## Test plan
- Reset then route:
  - Assert `rst_n` = 0. Check `out_valid` = 0000, all outs = 0, and `in_ready` = 1.
  - Send 16'h5555 to sel 00 with `out_ready` = 0. Next cycle check `out_valid` = 0001 and `out_a` = 16'h5555.
- Four lanes fill:
  - Send 5555, AAAA, 00FF, FF00 to sel 00, 01, 10, 11 on consecutive cycles with `out_ready` = 0.
  - Expect `out_valid` = 1111 and each out matching its word. A fifth send to sel 10 then sees `in_ready` = 0.
- Backpressure isolation:
  - Lane a is full and stalled.
  - A send of 16'h1234 to sel 01 is accepted. `out_a` stays 5555 and `out_b` becomes 1234.
- Same-cycle replace:
  - Lane c is full with 00FF and `out_ready[2]` = 1. Send 16'hBEEF to sel 10.
  - `in_ready` = 1, and next cycle `out_c` = BEEF with `out_valid[2]` still 1.
- Drain:
  - Raise `out_ready` = 1111 with no input. Next cycle `out_valid` = 0000 and out data is unchanged.
- Mid-operation reset:
  - Pulse `rst_n` low between edges with lanes full. All valid and data clear immediately.
  - A word presented in the cycle `rst_n` rises is not accepted until the following edge.
